// File: rtl/mips_pkg.sv
// mips_pkg: constants shared between the fetch stage and the control unit.
//   - opcode / funct field values
//   - PCSrc encodings for the next-PC mux
//   - fetch FSM state enum
//   - default reset PC and exception vector
package mips_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (inst[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Next-PC source select
  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_JUMP  = 2'b01;
  localparam logic [1:0] PC_JR    = 2'b10;
  localparam logic [1:0] PC_RSV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: purely combinational next-PC selection.
// Ports:
//   pc        in  32  address of the current instruction
//   index     in  26  inst[25:0] (jump index; low 16 bits are the branch immediate)
//   pc_src    in  2   PC_SEQ / PC_JUMP / PC_JR / reserved
//   branch    in  1   instruction is beq
//   zero      in  1   ALU equality result
//   jr_target in  32  register target for jr/jalr
//   pc_plus4  out 32  pc + 4 (link value)
//   next_pc   out 32  selected next PC, low bits not yet sanitised
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] index,
  input  logic [1:0]  pc_src,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic signed [31:0] br_off;
  logic        [31:0] br_target;
  logic        [31:0] jump_target;

  assign pc_plus4    = pc + 32'd4;
  // Word offset sign-extended and scaled to bytes; the add wraps modulo 2^32.
  assign br_off      = $signed({{14{index[15]}}, index[15:0], 2'b00});
  assign br_target   = pc_plus4 + $unsigned(br_off);
  assign jump_target = {pc_plus4[31:28], index, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC_SEQ:  next_pc = (branch && zero) ? br_target : pc_plus4;
      PC_JUMP: next_pc = jump_target;
      PC_JR:   next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage of the single-cycle MIPS core.
// Holds the PC, fetches one word over a req/ready handshake, holds it for the
// core until inst_done, then registers the next PC.
// Optional feature macro: PC_MISALIGN_TRAP_EN -- a misaligned next PC loads
// EXC_VEC and pulses misalign_trap in the first following FETCH cycle. When
// undefined the low two PC bits are simply cleared and the port is absent.
// Ports:
//   clk, reset (async, active-high)
//   imem_req/imem_addr out, imem_ready/imem_rdata in : instruction memory
//   inst, inst_valid, OpCode, Funct, pc, pc_plus4 out : to decode/control
//   inst_done, PCSrc, Branch, Zero, JrTarget in      : next-PC controls
//   misalign_trap out (only with PC_MISALIGN_TRAP_EN)
module inst_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
`endif
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        inst_done,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] JrTarget
`ifdef PC_MISALIGN_TRAP_EN
  , output logic      misalign_trap
`endif
);

  fetch_state_t state;
  logic [31:0]  next_pc;

  next_pc_calc u_next_pc (
    .pc        (pc),
    .index     (inst[25:0]),
    .pc_src    (PCSrc),
    .branch    (Branch),
    .zero      (Zero),
    .jr_target (JrTarget),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
  );

  assign imem_addr = pc;
  assign OpCode    = inst[31:26];
  assign Funct     = inst[5:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      inst       <= 32'd0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
`ifdef PC_MISALIGN_TRAP_EN
          // Trap flag lives only for the first FETCH cycle.
          misalign_trap <= 1'b0;
`endif
          if (imem_ready) begin
            inst       <= imem_rdata;
            state      <= S_EXEC;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          if (inst_done) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (next_pc[1:0] != 2'b00) begin
              pc            <= EXC_VEC;
              misalign_trap <= 1'b1;
            end else begin
              pc <= next_pc;
            end
`else
            pc <= next_pc & 32'hFFFF_FFFC;
`endif
            state      <= S_FETCH;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_done = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic [31:0] JrTarget = 32'd0;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  inst_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .OpCode     (OpCode),
    .Funct      (Funct),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .inst_done  (inst_done),
    .PCSrc      (PCSrc),
    .Branch     (Branch),
    .Zero       (Zero),
    .JrTarget   (JrTarget)
`ifdef PC_MISALIGN_TRAP_EN
    , .misalign_trap (misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a fetch request, then answer it immediately.
  task automatic fetch(input logic [31:0] word);
    int waited = 0;
    while (imem_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (imem_req !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL fetch_timeout: imem_req=%b after %0d cycles, required 1", imem_req, waited);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
  endtask

  task automatic retire(input logic [1:0] src, input logic br, input logic z, input logic [31:0] jr);
    PCSrc = src; Branch = br; Zero = z; JrTarget = jr;
    inst_done = 1'b1;
    tick();
    inst_done = 1'b0; PCSrc = 2'b00; Branch = 1'b0; Zero = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    n_cmp++; if (pc !== 32'h0040_0000) begin n_fail++; $display("FAIL rst_pc: got %h want 00400000", pc); end
    n_cmp++; if (pc_plus4 !== 32'h0040_0004) begin n_fail++; $display("FAIL rst_pc4: got %h want 00400004", pc_plus4); end
    n_cmp++; if (inst !== 32'd0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", inst); end
    reset = 1'b0;
    tick();
    // First edge after release only leaves IDLE.
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL first_addr: got %h want 00400000", imem_addr); end
  endtask

  task automatic test_wait_states();
    repeat (3) begin
      tick();
      n_cmp++; if (imem_req !== 1'b1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL wait_hold: req=%b valid=%b want 1/0", imem_req, inst_valid); end
    end
    fetch(32'h012A_4020);
    n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", inst_valid); end
    n_cmp++; if (inst !== 32'h012A_4020) begin n_fail++; $display("FAIL add_inst: got %h want 012a4020", inst); end
    n_cmp++; if (OpCode !== 6'h00 || Funct !== 6'h20) begin n_fail++; $display("FAIL add_fields: got %h/%h want 00/20", OpCode, Funct); end
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL exec_req: got %b want 0", imem_req); end
    retire(2'b00, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin n_fail++; $display("FAIL seq_next: req=%b addr=%h want 1/00400004", imem_req, imem_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid: got %b want 0", inst_valid); end
  endtask

  task automatic test_branch();
    fetch(32'h03E0_0008);
    retire(2'b10, 1'b0, 1'b0, 32'h0040_0010);
    n_cmp++; if (pc !== 32'h0040_0010) begin n_fail++; $display("FAIL jr_setup: got %h want 00400010", pc); end
    fetch(32'h1109_FFFF);
    n_cmp++; if (OpCode !== 6'h04 || pc_plus4 !== 32'h0040_0014) begin n_fail++; $display("FAIL beq_fields: op=%h pc4=%h want 04/00400014", OpCode, pc_plus4); end
    retire(2'b00, 1'b1, 1'b1, 32'd0);
    n_cmp++; if (imem_addr !== 32'h0040_0010) begin n_fail++; $display("FAIL beq_taken: got %h want 00400010", imem_addr); end
    fetch(32'h1109_FFFF);
    retire(2'b00, 1'b1, 1'b0, 32'd0);
    n_cmp++; if (pc !== 32'h0040_0014) begin n_fail++; $display("FAIL beq_not_taken: got %h want 00400014", pc); end
    fetch(32'h1109_0003);
    retire(2'b00, 1'b0, 1'b1, 32'd0);
    n_cmp++; if (pc !== 32'h0040_0018) begin n_fail++; $display("FAIL nobranch_zero: got %h want 00400018", pc); end
    fetch(32'h1109_0003);
    retire(2'b00, 1'b1, 1'b1, 32'd0);
    n_cmp++; if (pc !== 32'h0040_0028) begin n_fail++; $display("FAIL beq_fwd: got %h want 00400028", pc); end
  endtask

  task automatic test_jump();
    fetch(32'h03E0_0008);
    retire(2'b10, 1'b0, 1'b0, 32'h0040_0020);
    fetch(32'h0810_0008);
    retire(2'b01, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (pc !== 32'h0040_0020) begin n_fail++; $display("FAIL j_target: got %h want 00400020", pc); end
    fetch(32'h0BFF_FFFF);
    retire(2'b01, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (pc !== 32'h0FFF_FFFC) begin n_fail++; $display("FAIL j_max: got %h want 0ffffffc", pc); end
    fetch(32'h03E0_0008);
    retire(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC);
    n_cmp++; if (pc_plus4 !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc4: got %h want 00000000", pc_plus4); end
    fetch(32'h0000_0000);
    retire(2'b00, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (pc !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_seq: got %h want 00000000", pc); end
    // Reserved select behaves as sequential even with a taken branch pending.
    fetch(32'h1109_FFFF);
    retire(2'b11, 1'b1, 1'b1, 32'h1234_5678);
    n_cmp++; if (pc !== 32'h0000_0004) begin n_fail++; $display("FAIL rsv_src: got %h want 00000004", pc); end
  endtask

  task automatic test_jr_misalign();
    fetch(32'h0200_0008);
    retire(2'b10, 1'b0, 1'b0, 32'h0040_0102);
`ifdef PC_MISALIGN_TRAP_EN
    n_cmp++; if (pc !== 32'h8000_0008) begin n_fail++; $display("FAIL trap_pc: got %h want 80000008", pc); end
    n_cmp++; if (misalign_trap !== 1'b1) begin n_fail++; $display("FAIL trap_pulse: got %b want 1", misalign_trap); end
    tick();
    n_cmp++; if (misalign_trap !== 1'b0) begin n_fail++; $display("FAIL trap_clear: got %b want 0", misalign_trap); end
`else
    n_cmp++; if (pc !== 32'h0040_0100) begin n_fail++; $display("FAIL jr_align: got %h want 00400100", pc); end
`endif
  endtask

  task automatic test_back_to_back();
    int t0 = 0;
    fetch(32'h03E0_0008);
    retire(2'b10, 1'b0, 1'b0, 32'h0040_0200);
    t0 = $time;
    fetch(32'h012A_4020);
    retire(2'b00, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (($time - t0) != 20 || imem_addr !== 32'h0040_0204) begin n_fail++; $display("FAIL b2b: took %0t addr=%h want 20/00400204", $time - t0, imem_addr); end
  endtask

  task automatic test_reset_mid_fetch();
    // Now in FETCH with a pending request.
    reset = 1'b1;
    #2;
    n_cmp++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL async_ctrl: req=%b valid=%b want 0/0", imem_req, inst_valid); end
    n_cmp++; if (pc !== 32'h0040_0000 || inst !== 32'd0 || OpCode !== 6'd0 || Funct !== 6'd0) begin n_fail++; $display("FAIL async_data: pc=%h inst=%h want 00400000/0", pc, inst); end
    tick();
    reset = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    n_cmp++; if (inst !== 32'd0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ready: inst=%h valid=%b want 0/0", inst, inst_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL refetch: req=%b addr=%h want 1/00400000", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_branch();
    test_jump();
    test_jr_misalign();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
